adder_result_accumulator: RTL and testbench
===========================================

# adder_result_accumulator

Downstream stage for the registered adder: consumes the adder's result stream (`c` qualified by `valid`) and sums each block of BLOCK_LEN consecutive valid results into one block sum. Each block sum is presented on a one-entry output register with a valid/ready handshake. Since the adder has no backpressure, this block never stalls its input. It absorbs output stalls by flagging overruns instead.

## Interface
- IN_W, 5: width of adder result `c` (4-bit operands + carry)
- OUT_W, 8: accumulator and block-sum width
- BLOCK_LEN, 4: valid samples per block; legal range 2..255
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset: synchronous, active-high; one clock, synchronous reset
- in_valid  input  1  in_data is a valid adder result this cycle (driven from adder `valid`)
- in_data  input  IN_W  adder result (driven from adder `c`), zero-extended to OUT_W
- out_valid  output  1  out_sum/out_ovf hold a block result
- out_ready  input  1  consumer accepts the result this cycle
- out_sum  output  OUT_W  block sum
- out_ovf  output  1  this block's sum exceeded 2^OUT_W-1
- overrun  output  1  sticky: a completed block was dropped because the output was still pending

## Operation
- Collect side: `acc` (OUT_W), `ovf_acc` (1), `cnt` (8 bits, 0..BLOCK_LEN-1).
  - When in_valid=0, nothing changes.
  - When in_valid=1 and `cnt` < BLOCK_LEN-1: acc += in_data, cnt++, and ovf_acc |= carry out of OUT_W.
  - When in_valid=1 and `cnt` = BLOCK_LEN-1 (block completes): the final sum acc+in_data is offered to the output. Then acc=0, cnt=0, ovf_acc=0.
- Output side: two states, EMPTY (out_valid=0) and PEND (out_valid=1). Handshake: a result transfers on a cycle with out_valid=1 and out_ready=1.
  - EMPTY + block completes: load the result and go to PEND.
  - PEND + transfer + no completion: go to EMPTY.
  - PEND + transfer + completion in the same cycle: load the new result and stay in PEND. This is not an overrun.
  - PEND + no transfer + completion: drop the new result, hold the old one unchanged, and set `overrun`=1.
- Rules for the consumer side:
  - out_sum and out_ovf are stable while out_valid=1 and out_ready=0.
  - out_ready is ignored in EMPTY.
- `overrun` clears only on rst.
- Arithmetic: in_data is unsigned and zero-extended. Overflow is detected per addition on the unsigned carry out of bit OUT_W-1. out_ovf = ovf_acc of the block, OR'd with the final addition's carry.

## Timing
- Reset values (rst high at a rising edge): out_valid=0, out_sum=0, out_ovf=0, overrun=0, acc=0, cnt=0, output state EMPTY.
- rst has priority over all other activity. A reset mid-block discards the partial sum. A reset while in PEND discards the held result.
- Latency: the rising edge that samples the BLOCK_LEN-th valid input also loads out_sum. out_valid is therefore high in the following cycle (1-cycle latency from the last sample).
- Throughput: one input per cycle, sustained. A block result every BLOCK_LEN cycles at most. With out_ready tied high, no overrun is possible for BLOCK_LEN≥2.
- Gaps in in_valid are allowed anywhere and do not reset `cnt`.

## Configuration
- `ADDER_ACC_SAT_EN` defined: on overflow, acc and the final sum saturate at 2^OUT_W-1 and stay there for the rest of the block. out_ovf is still reported.
- `ADDER_ACC_SAT_EN` undefined: the sum wraps modulo 2^OUT_W. out_ovf is reported.

## Test plan
- Reset, then in_data 1,2,3,4 on consecutive cycles with out_ready=1 -> out_valid high for 1 cycle the cycle after sample 4, out_sum=10, out_ovf=0, overrun=0.
- Inputs 5,_,7,_,_,9,1 (underscore = in_valid=0) -> one result out_sum=22, appearing the cycle after the `1` sample. Gaps do not reset the count.
- Override OUT_W=6, inputs 31,31,31,31 -> without the macro: out_sum=60, out_ovf=1. With `ADDER_ACC_SAT_EN`: out_sum=63, out_ovf=1.
- out_ready=0, feed blocks {1,1,1,1} then {2,2,2,2} -> out_sum stays 4, out_valid stays 1, overrun=1 after the 8th sample. Then out_ready=1 for one cycle -> out_valid=0.
- Hold out_ready=0 until the cycle the 2nd block's last sample arrives, then pulse out_ready=1 in that cycle -> first result (4) transfers, out_sum becomes 8 with out_valid still 1, overrun=0.
- Feed 3,3 then assert rst for one cycle, then feed 1,1,1,1 -> out_valid=0 through the reset, next result out_sum=4 (partial 6 discarded).

Source files
------------

// File: rtl/adder_result_accumulator_if.sv
// Handshake bundle between the adder result stream, the block accumulator and its consumer.
interface adder_result_accumulator_if #(
    parameter int unsigned IN_W  = 5,
    parameter int unsigned OUT_W = 8
) ();
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_sum;
    logic             out_ovf;
    logic             overrun;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_sum,
        input  out_ovf,
        input  overrun
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_sum,
        output out_ovf,
        output overrun
    );
endinterface

// File: rtl/adder_result_accumulator.sv
// Sums blocks of BLOCK_LEN valid adder results into a one-entry valid/ready output register.
// Optional macro ADDER_ACC_SAT_EN: saturate instead of wrapping on overflow.
module adder_result_accumulator #(
    parameter int unsigned IN_W      = 5,
    parameter int unsigned OUT_W     = 8,
    parameter int unsigned BLOCK_LEN = 4
) (
    input logic                        clk,
    input logic                        rst,
    adder_result_accumulator_if.slave  bus
);
    localparam logic [7:0] LastCnt = 8'(BLOCK_LEN - 1);

    typedef enum logic [0:0] {StEmpty, StPend} state_e;

    state_e           state_q, state_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [OUT_W-1:0] out_sum_q, out_sum_d;
    logic             out_ovf_q, out_ovf_d;
    logic             overrun_q, overrun_d;

    logic [OUT_W-1:0] in_ext;
    logic [OUT_W:0]   sum_full;
    logic             carry;
    logic [OUT_W-1:0] next_acc;
    logic             complete;
    logic             transfer;

    assign in_ext   = OUT_W'(bus.in_data);
    assign sum_full = {1'b0, acc_q} + {1'b0, in_ext};
    assign carry    = sum_full[OUT_W];

`ifdef ADDER_ACC_SAT_EN
    // Once saturated, any further nonzero add carries again, so acc sticks at max.
    assign next_acc = carry ? {OUT_W{1'b1}} : sum_full[OUT_W-1:0];
`else
    assign next_acc = sum_full[OUT_W-1:0];
`endif

    assign complete = bus.in_valid && (cnt_q == LastCnt);
    assign transfer = (state_q == StPend) && bus.out_ready;

    always_comb begin
        acc_d     = acc_q;
        ovf_acc_d = ovf_acc_q;
        cnt_d     = cnt_q;
        if (bus.in_valid) begin
            if (complete) begin
                acc_d     = '0;
                ovf_acc_d = 1'b0;
                cnt_d     = '0;
            end else begin
                acc_d     = next_acc;
                ovf_acc_d = ovf_acc_q | carry;
                cnt_d     = 8'(cnt_q + 8'd1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        out_sum_d = out_sum_q;
        out_ovf_d = out_ovf_q;
        overrun_d = overrun_q;
        unique case (state_q)
            StEmpty: begin
                if (complete) begin
                    out_sum_d = next_acc;
                    out_ovf_d = ovf_acc_q | carry;
                    state_d   = StPend;
                end
            end
            StPend: begin
                if (transfer) begin
                    if (complete) begin
                        out_sum_d = next_acc;
                        out_ovf_d = ovf_acc_q | carry;
                    end else begin
                        state_d = StEmpty;
                    end
                end else if (complete) begin
                    // Output still held: drop the new block and flag it.
                    overrun_d = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StEmpty;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= '0;
            out_sum_q <= '0;
            out_ovf_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ovf_acc_q <= ovf_acc_d;
            cnt_q     <= cnt_d;
            out_sum_q <= out_sum_d;
            out_ovf_q <= out_ovf_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.out_valid = (state_q == StPend);
    assign bus.out_sum   = out_sum_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_adder_result_accumulator.sv
// Directed bench for adder_result_accumulator; a second instance with OUT_W=6 covers overflow.
module tb_adder_result_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    adder_result_accumulator_if #(.IN_W(5), .OUT_W(8)) bus ();
    adder_result_accumulator_if #(.IN_W(5), .OUT_W(6)) bus6 ();

    assign bus6.in_valid  = bus.in_valid;
    assign bus6.in_data   = bus.in_data;
    assign bus6.out_ready = bus.out_ready;

    adder_result_accumulator #(.IN_W(5), .OUT_W(8), .BLOCK_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    adder_result_accumulator #(.IN_W(5), .OUT_W(6), .BLOCK_LEN(4)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // Drive one cycle of stimulus and return 1 time unit after the sampling edge.
    task automatic cyc(input logic v, input logic [4:0] d, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset
        rst = 1'b1;
        cyc(1'b0, 5'd0, 1'b0);
        rst = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
        chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);

        // 1,2,3,4 back to back
        cyc(1'b1, 5'd1, 1'b1);
        cyc(1'b1, 5'd2, 1'b1);
        cyc(1'b1, 5'd3, 1'b1);
        chk("b1_not_yet", 32'(bus.out_valid), 32'd0);
        cyc(1'b1, 5'd4, 1'b1);
        chk("b1_valid", 32'(bus.out_valid), 32'd1);
        chk("b1_sum", 32'(bus.out_sum), 32'd10);
        chk("b1_ovf", 32'(bus.out_ovf), 32'd0);
        cyc(1'b0, 5'd0, 1'b1);
        chk("b1_drained", 32'(bus.out_valid), 32'd0);
        chk("b1_overrun", 32'(bus.overrun), 32'd0);

        // Gaps do not reset the count
        cyc(1'b1, 5'd5, 1'b1);
        cyc(1'b0, 5'd0, 1'b1);
        cyc(1'b1, 5'd7, 1'b1);
        cyc(1'b0, 5'd0, 1'b1);
        cyc(1'b0, 5'd0, 1'b1);
        cyc(1'b1, 5'd9, 1'b1);
        chk("gap_not_yet", 32'(bus.out_valid), 32'd0);
        cyc(1'b1, 5'd1, 1'b1);
        chk("gap_valid", 32'(bus.out_valid), 32'd1);
        chk("gap_sum", 32'(bus.out_sum), 32'd22);
        cyc(1'b0, 5'd0, 1'b1);
        chk("gap_drained", 32'(bus.out_valid), 32'd0);

        // 31 x4: wraps/saturates at 6 bits, fits in 8 bits
        for (int i = 0; i < 4; i++) cyc(1'b1, 5'd31, 1'b1);
        chk("w8_sum", 32'(bus.out_sum), 32'd124);
        chk("w8_ovf", 32'(bus.out_ovf), 32'd0);
        chk("w6_valid", 32'(bus6.out_valid), 32'd1);
`ifdef ADDER_ACC_SAT_EN
        chk("w6_sum", 32'(bus6.out_sum), 32'd63);
`else
        chk("w6_sum", 32'(bus6.out_sum), 32'd60);
`endif
        chk("w6_ovf", 32'(bus6.out_ovf), 32'd1);
        cyc(1'b0, 5'd0, 1'b1);
        chk("w6_drained", 32'(bus6.out_valid), 32'd0);

        // Stalled output: second block is dropped and overrun latches
        for (int i = 0; i < 4; i++) cyc(1'b1, 5'd1, 1'b0);
        chk("stall_valid1", 32'(bus.out_valid), 32'd1);
        chk("stall_sum1", 32'(bus.out_sum), 32'd4);
        for (int i = 0; i < 3; i++) cyc(1'b1, 5'd2, 1'b0);
        chk("stall_no_ovr_yet", 32'(bus.overrun), 32'd0);
        cyc(1'b1, 5'd2, 1'b0);
        chk("stall_sum_held", 32'(bus.out_sum), 32'd4);
        chk("stall_valid_held", 32'(bus.out_valid), 32'd1);
        chk("stall_overrun", 32'(bus.overrun), 32'd1);
        cyc(1'b0, 5'd0, 1'b1);
        chk("stall_drained", 32'(bus.out_valid), 32'd0);
        chk("stall_overrun_sticky", 32'(bus.overrun), 32'd1);
        cyc(1'b0, 5'd0, 1'b0);
        chk("ovr_sticky_idle", 32'(bus.overrun), 32'd1);

        rst = 1'b1;
        cyc(1'b0, 5'd0, 1'b0);
        rst = 1'b0;
        chk("ovr_cleared", 32'(bus.overrun), 32'd0);

        // Transfer and completion on the same edge: reload, no overrun
        for (int i = 0; i < 4; i++) cyc(1'b1, 5'd1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 5'd2, 1'b0);
        chk("same_held_sum", 32'(bus.out_sum), 32'd4);
        cyc(1'b1, 5'd2, 1'b1);
        chk("same_valid", 32'(bus.out_valid), 32'd1);
        chk("same_sum", 32'(bus.out_sum), 32'd8);
        chk("same_overrun", 32'(bus.overrun), 32'd0);
        cyc(1'b0, 5'd0, 1'b1);
        chk("same_drained", 32'(bus.out_valid), 32'd0);

        // Mid-block reset discards the partial sum
        cyc(1'b1, 5'd3, 1'b1);
        cyc(1'b1, 5'd3, 1'b1);
        rst = 1'b1;
        cyc(1'b0, 5'd0, 1'b1);
        rst = 1'b0;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 5'd1, 1'b1);
        chk("mid_rst_not_yet", 32'(bus.out_valid), 32'd0);
        cyc(1'b1, 5'd1, 1'b1);
        chk("mid_rst_valid2", 32'(bus.out_valid), 32'd1);
        chk("mid_rst_sum", 32'(bus.out_sum), 32'd4);

        // Reset while pending discards the held result
        rst = 1'b1;
        cyc(1'b0, 5'd0, 1'b0);
        rst = 1'b0;
        chk("pend_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("pend_rst_sum", 32'(bus.out_sum), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
